// File: rtl/spi_rx_frame.sv
// SPI slave receive front end: synchronises the SPI pins, assembles whole frames,
// and holds one frame for a valid/ready consumer. Optional macro: SPI_RX_FRAME_TIMEOUT_EN.
module spi_rx_frame #(
    parameter int unsigned WORD_WIDTH     = 2,
    parameter int unsigned WORD_COUNT     = 16,
    parameter int unsigned SYNC_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned FRAME_BITS    = WORD_WIDTH * WORD_COUNT,
    localparam int unsigned CNT_W         = $clog2(FRAME_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  spi_clk,
    input  logic                  spi_en,
    input  logic                  spi_data,
    input  logic                  sample_negedge,
    input  logic                  msb_first,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  overrun,
    output logic                  short_frame
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [SYNC_DEPTH-1:0] sclk_sync_q, en_sync_q, dat_sync_q;
    logic                  sclk_prev_q, en_prev_q;
    logic                  neg_q, neg_d;
    logic                  msb_q, msb_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, shifted_c;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  ovr_q, ovr_d;
    logic                  short_q, short_d;
    logic                  complete_c;
    logic                  sclk_s, en_s, dat_s;
    logic                  sample_edge_c, en_rise_c, en_fall_c;

`ifdef SPI_RX_FRAME_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d;
`endif

    // Pin synchronisers plus one extra stage for edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_sync_q <= '0;
            en_sync_q   <= '0;
            dat_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            en_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_DEPTH-2:0], spi_clk};
            en_sync_q   <= {en_sync_q[SYNC_DEPTH-2:0], spi_en};
            dat_sync_q  <= {dat_sync_q[SYNC_DEPTH-2:0], spi_data};
            sclk_prev_q <= sclk_sync_q[SYNC_DEPTH-1];
            en_prev_q   <= en_sync_q[SYNC_DEPTH-1];
        end
    end

    assign sclk_s        = sclk_sync_q[SYNC_DEPTH-1];
    assign en_s          = en_sync_q[SYNC_DEPTH-1];
    assign dat_s         = dat_sync_q[SYNC_DEPTH-1];
    assign sample_edge_c = neg_q ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
    assign en_rise_c     = en_s & ~en_prev_q;
    assign en_fall_c     = ~en_s & en_prev_q;
    assign shifted_c     = msb_q ? {shift_q[FRAME_BITS-2:0], dat_s}
                                 : {dat_s, shift_q[FRAME_BITS-1:1]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            neg_q   <= 1'b0;
            msb_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
            short_q <= 1'b0;
`ifdef SPI_RX_FRAME_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            neg_q   <= neg_d;
            msb_q   <= msb_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
            short_q <= short_d;
`ifdef SPI_RX_FRAME_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // Frame FSM; an enable drop takes priority over a coincident sample edge
    always_comb begin
        state_d    = state_q;
        neg_d      = neg_q;
        msb_d      = msb_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        short_d    = 1'b0;
        complete_c = 1'b0;
`ifdef SPI_RX_FRAME_TIMEOUT_EN
        idle_d     = '0;
`endif
        case (state_q)
            IDLE: begin
                if (en_rise_c) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    neg_d   = sample_negedge;
                    msb_d   = msb_first;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (en_fall_c) begin
                    short_d = (cnt_q < CNT_W'(FRAME_BITS));
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sample_edge_c) begin
                    shift_d = shifted_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        complete_c = 1'b1;
                        state_d    = DONE;
                    end
`ifdef SPI_RX_FRAME_TIMEOUT_EN
                end else if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    short_d = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    idle_d = idle_q + TO_W'(1);
`endif
                end
            end
            DONE: begin
                if (en_fall_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: accept-and-reload in one cycle, drop the new frame if full
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (complete_c && (!valid_q || frame_ready)) begin
            valid_d = 1'b1;
            data_d  = shifted_c;
        end else begin
            if (complete_c) begin
                ovr_d = 1'b1;
            end
            if (valid_q && frame_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    assign frame_valid = valid_q;
    assign frame_data  = data_q;
    assign bit_count   = cnt_q;
    assign overrun     = ovr_q;
    assign short_frame = short_q;

endmodule
